// File: rtl/hash_msg_sequencer.sv
// Streams a byte-length message from word-addressed RAM into the Keccak padder,
// always ending with one is_last word. Optional macro: SEQ_BYTESWAP_EN.
module hash_msg_sequencer #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] msg_base,
  input  logic [LEN_W-1:0]  msg_len,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rd_data,
  output logic [31:0]       pad_in,
  output logic              pad_in_ready,
  output logic              pad_is_last,
  output logic [1:0]        pad_byte_num,
  input  logic              pad_buffer_full,
  output logic [1:0]        state_dbg
);

  // Padder handshake: a word moves on any cycle where pad_in_ready=1 and
  // pad_buffer_full=0; otherwise pad_in/pad_is_last/pad_byte_num hold.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_TAIL, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  fetch_left_q;
  logic [LEN_W-1:0]  xfer_left_q;
  logic [1:0]        rem_q;
  logic              inflight_q;
  logic [31:0]       fifo_q [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        occ_q;

  logic [31:0] ram_word;
  logic [31:0] head_word;
  logic        head_valid;
  logic        head_last;
  logic        issue;
  logic        accept;
  logic        push;
  logic        pop;
  logic [LEN_W-1:0] word_count;

  function automatic logic [31:0] order_word(input logic [31:0] w);
`ifdef SEQ_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Bytes beyond the valid count are zeroed; applied after any byte swap.
  function automatic logic [31:0] mask_tail(input logic [31:0] w, input logic [1:0] r);
    logic [31:0] m;
    case (r)
      2'd1:    m = {w[31:24], 24'h0};
      2'd2:    m = {w[31:16], 16'h0};
      2'd3:    m = {w[31:8], 8'h0};
      default: m = w;
    endcase
    return m;
  endfunction

  assign word_count = {2'b00, msg_len[LEN_W-1:2]} + LEN_W'(msg_len[1:0] != 2'd0);
  assign ram_word   = order_word(mem_rd_data);

  // Returning read data bypasses the FIFO when it is empty, so the first word
  // reaches the padder in the cycle after its read.
  assign head_valid = (state_q == S_RUN) && ((occ_q != 2'd0) || inflight_q);
  assign head_word  = (occ_q != 2'd0) ? fifo_q[rd_ptr_q] : ram_word;
  assign head_last  = (xfer_left_q == LEN_W'(1)) && (rem_q != 2'd0);
  assign accept     = head_valid && !pad_buffer_full;

  assign issue = (state_q == S_RUN) && (fetch_left_q != '0) &&
                 (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd2);
  assign push  = inflight_q && !(accept && (occ_q == 2'd0));
  assign pop   = accept && (occ_q != 2'd0);

  assign mem_rd_en = issue;
  assign mem_addr  = issue ? addr_q : '0;
  assign state_dbg = state_q;

  always_comb begin
    state_d      = state_q;
    busy         = 1'b0;
    done         = 1'b0;
    pad_in       = 32'h0;
    pad_in_ready = 1'b0;
    pad_is_last  = 1'b0;
    pad_byte_num = 2'd0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (msg_len == '0) ? S_TAIL : S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (head_valid) begin
          pad_in_ready = 1'b1;
          if (head_last) begin
            pad_in       = mask_tail(head_word, rem_q);
            pad_is_last  = 1'b1;
            pad_byte_num = rem_q;
          end else begin
            pad_in = head_word;
          end
        end
        if (accept && (xfer_left_q == LEN_W'(1)))
          state_d = (rem_q != 2'd0) ? S_DONE : S_TAIL;
      end
      S_TAIL: begin
        busy         = 1'b1;
        pad_in_ready = 1'b1;
        pad_is_last  = 1'b1;
        if (!pad_buffer_full) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      fetch_left_q <= '0;
      xfer_left_q  <= '0;
      rem_q        <= 2'd0;
      inflight_q   <= 1'b0;
      fifo_q[0]    <= 32'h0;
      fifo_q[1]    <= 32'h0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      occ_q        <= 2'd0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if ((state_q == S_IDLE) && start) begin
        addr_q       <= msg_base;
        fetch_left_q <= word_count;
        xfer_left_q  <= word_count;
        rem_q        <= msg_len[1:0];
      end else begin
        if (issue) begin
          addr_q       <= addr_q + ADDR_W'(1);
          fetch_left_q <= fetch_left_q - LEN_W'(1);
        end
        if (accept) xfer_left_q <= xfer_left_q - LEN_W'(1);
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= ram_word;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_hash_msg_sequencer.sv
// Bench for hash_msg_sequencer: RAM model, padder monitor and a byte-level
// reference model of the expected padder word stream.
module tb_hash_msg_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [9:0]  msg_base;
  logic [15:0] msg_len;
  logic        busy, done, mem_rd_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rd_data;
  logic [31:0] pad_in;
  logic        pad_in_ready, pad_is_last;
  logic [1:0]  pad_byte_num;
  logic        pad_buffer_full;
  logic [1:0]  state_dbg;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:1023];
  logic [34:0] obs_q[$];
  logic [34:0] exp_q[$];
  logic [9:0]  rd_addr_q[$];
  logic [9:0]  exp_addr_q[$];

  bit   cap;
  int   tcyc, start_t, first_rd_t, first_rdy_t, last_xfer_t, done_t, done_cnt;
  int   stab_checks, stab_err, bn_err;
  bit   prev_stall;
  logic [35:0] prev_val;

  hash_msg_sequencer #(.ADDR_W(10), .LEN_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .msg_base(msg_base), .msg_len(msg_len),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .pad_in(pad_in), .pad_in_ready(pad_in_ready),
    .pad_is_last(pad_is_last), .pad_byte_num(pad_byte_num),
    .pad_buffer_full(pad_buffer_full), .state_dbg(state_dbg)
  );

  // ---------------- clock / RAM model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data is only meaningful the cycle after a read; garbage otherwise.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    else           mem_rd_data <= $urandom;
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    tcyc++;
    if (start) start_t = tcyc;
    if (cap) begin
      if (mem_rd_en) begin
        rd_addr_q.push_back(mem_addr);
        if (first_rd_t < 0) first_rd_t = tcyc;
      end
      if (pad_in_ready && first_rdy_t < 0) first_rdy_t = tcyc;
      if (pad_in_ready && !pad_buffer_full) begin
        obs_q.push_back({pad_is_last, pad_byte_num, pad_in});
        last_xfer_t = tcyc;
      end
      if (done) begin
        done_cnt++;
        done_t = tcyc;
      end
      if (prev_stall) begin
        stab_checks++;
        if ({pad_in_ready, pad_is_last, pad_byte_num, pad_in} !== prev_val) stab_err++;
      end
      prev_stall = pad_in_ready && pad_buffer_full;
      prev_val   = {pad_in_ready, pad_is_last, pad_byte_num, pad_in};
      if (!pad_is_last && pad_byte_num != 2'd0) bn_err++;
    end
  end

  // ---------------- reference model ----------------
  // Message = byte stream taken from RAM; packed 4 per word MSB-first, zero
  // padded, one extra empty word when the length is a multiple of 4.
  function automatic void build_exp(input int base, input int len);
    logic [7:0]  b [$];
    logic [31:0] word;
    logic [31:0] w;
    int          idx;
    exp_q.delete();
    exp_addr_q.delete();
    for (int k = 0; k < len; k++) begin
      word = mem[(base + k / 4) % 1024];
`ifdef SEQ_BYTESWAP_EN
      b.push_back(word[8 * (k % 4) +: 8]);
`else
      b.push_back(word[31 - 8 * (k % 4) -: 8]);
`endif
    end
    for (int i = 0; i < (len + 3) / 4; i++) exp_addr_q.push_back(10'((base + i) % 1024));
    for (int wi = 0; wi <= len / 4; wi++) begin
      w = 32'h0;
      for (int j = 0; j < 4; j++) begin
        idx = 4 * wi + j;
        if (idx < len) w[31 - 8 * j -: 8] = b[idx];
      end
      exp_q.push_back({(wi == len / 4), (wi == len / 4) ? 2'(len % 4) : 2'd0, w});
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_cap();
    obs_q.delete();
    rd_addr_q.delete();
    first_rd_t = -1; first_rdy_t = -1; last_xfer_t = -1; done_t = -1; start_t = -1;
    done_cnt = 0; stab_checks = 0; stab_err = 0; bn_err = 0; prev_stall = 0;
  endtask

  task automatic drive_start(input int base, input int len);
    @(posedge clk); #1;
    start = 1'b1; msg_base = 10'(base); msg_len = 16'(len);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: padder always ready; 1: random backpressure; 2: 5-cycle stall after 3rd transfer
  task automatic drive_until_done(input int mode);
    int n, stall_left;
    bit stalled;
    n = 0; stall_left = 0; stalled = 0;
    while (done_cnt == 0 && n < 3000) begin
      if (mode == 1) pad_buffer_full = ($urandom_range(0, 99) < 30);
      else if (mode == 2) begin
        if (stall_left > 0) begin
          pad_buffer_full = 1'b1; stall_left--;
        end else if (!stalled && obs_q.size() == 3) begin
          pad_buffer_full = 1'b1; stall_left = 4; stalled = 1;
        end else pad_buffer_full = 1'b0;
      end else pad_buffer_full = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    pad_buffer_full = 1'b0;
    checks++;
    if (done_cnt == 0) begin
      failures++;
      $display("FAIL done_timeout: no done after %0d cycles, required a done pulse", n);
    end
    repeat (3) begin @(posedge clk); #1; end
    cap = 1'b0;
  endtask

  task automatic run_msg(input int base, input int len, input int mode);
    clear_cap();
    cap = 1'b1;
    drive_start(base, len);
    drive_until_done(mode);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; start = 1'b0; msg_base = '0; msg_len = '0; pad_buffer_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, mem_rd_en, mem_addr, pad_in, pad_in_ready, pad_is_last, pad_byte_num} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b done=%b rd=%b addr=%h pad=%h rdy=%b last=%b bn=%0d, required all 0",
               busy, done, mem_rd_en, mem_addr, pad_in, pad_in_ready, pad_is_last, pad_byte_num);
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, mem_rd_en, pad_in_ready} !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_reset: busy/rd/rdy=%b required 000", {busy, mem_rd_en, pad_in_ready});
    end
  endtask

  task automatic test_len1();
    logic [34:0] want;
`ifdef SEQ_BYTESWAP_EN
    want = {1'b1, 2'd1, 32'hEF000000};
`else
    want = {1'b1, 2'd1, 32'h90000000};
`endif
    mem[5] = 32'h90ABCDEF;
    run_msg(5, 1, 0);
    checks++;
    if (rd_addr_q.size() != 1 || rd_addr_q[0] !== 10'd5) begin
      failures++; $display("FAIL len1_reads: got %0d reads, required 1 at addr 5", rd_addr_q.size());
    end
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== want) begin
      failures++; $display("FAIL len1_word: got %0d xfers first=%h, required 1 xfer %h", obs_q.size(),
                           (obs_q.size() > 0) ? obs_q[0] : 35'h0, want);
    end
    checks++;
    if (done_cnt != 1 || done_t - last_xfer_t != 1) begin
      failures++; $display("FAIL len1_done: got count=%0d gap=%0d, required count=1 gap=1", done_cnt, done_t - last_xfer_t);
    end
    checks++;
    if (first_rd_t - start_t != 1 || first_rdy_t - start_t != 2) begin
      failures++; $display("FAIL len1_latency: got rd@%0d rdy@%0d, required rd@1 rdy@2",
                           first_rd_t - start_t, first_rdy_t - start_t);
    end
  endtask

  task automatic test_len4();
    logic [31:0] w0;
`ifdef SEQ_BYTESWAP_EN
    w0 = 32'hEFCDAB90;
`else
    w0 = 32'h90ABCDEF;
`endif
    mem[5] = 32'h90ABCDEF;
    run_msg(5, 4, 0);
    checks++;
    if (rd_addr_q.size() != 1) begin
      failures++; $display("FAIL len4_reads: got %0d, required 1", rd_addr_q.size());
    end
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== {1'b0, 2'd0, w0} || obs_q[1] !== {1'b1, 2'd0, 32'h0}) begin
      failures++; $display("FAIL len4_words: got %0d xfers, required {0,0,%h} then {1,0,0}", obs_q.size(), w0);
    end
  endtask

  task automatic test_len0();
    run_msg(7, 0, 0);
    checks++;
    if (rd_addr_q.size() != 0) begin
      failures++; $display("FAIL len0_reads: got %0d, required 0", rd_addr_q.size());
    end
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== {1'b1, 2'd0, 32'h0}) begin
      failures++; $display("FAIL len0_word: got %0d xfers, required one empty is_last word", obs_q.size());
    end
    checks++;
    if (first_rdy_t - start_t != 1 || done_cnt != 1) begin
      failures++; $display("FAIL len0_timing: got rdy@%0d done_cnt=%0d, required rdy@1 done_cnt=1",
                           first_rdy_t - start_t, done_cnt);
    end
  endtask

  task automatic test_stall71();
    for (int i = 0; i < 18; i++) mem[i] = {4{8'(i + 1)}};
    build_exp(0, 71);
    run_msg(0, 71, 2);
    checks++;
    if (obs_q.size() != 18) begin
      failures++; $display("FAIL stall71_count: got %0d xfers, required 18", obs_q.size());
    end
    for (int i = 0; i < 18 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL stall71_word[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (obs_q.size() == 0 || obs_q[obs_q.size() - 1] !== {1'b1, 2'd3, 32'h12121200}) begin
      failures++; $display("FAIL stall71_last: got %h, required %h",
                           (obs_q.size() > 0) ? obs_q[obs_q.size() - 1] : 35'h0, {1'b1, 2'd3, 32'h12121200});
    end
    checks++;
    if (stab_checks < 4 || stab_err != 0) begin
      failures++; $display("FAIL stall71_stable: got %0d unstable of %0d stalled cycles, required 0 of >=4",
                           stab_err, stab_checks);
    end
    checks++;
    if (rd_addr_q.size() != 18) begin
      failures++; $display("FAIL stall71_reads: got %0d, required 18", rd_addr_q.size());
    end
  endtask

  task automatic test_byteswap();
    logic [31:0] want;
`ifdef SEQ_BYTESWAP_EN
    want = 32'hAABB0000;
`else
    want = 32'hDDCC0000;
`endif
    mem[40] = 32'hDDCCBBAA;
    run_msg(40, 2, 0);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== {1'b1, 2'd2, want}) begin
      failures++; $display("FAIL byteswap_word: got %0d xfers first=%h, required %h", obs_q.size(),
                           (obs_q.size() > 0) ? obs_q[0] : 35'h0, {1'b1, 2'd2, want});
    end
  endtask

  task automatic test_back_to_back();
    int lens [2];
    int bases [2];
    lens[0] = 40; bases[0] = 200;
    lens[1] = 13; bases[1] = 1020;
    for (int t = 0; t < 2; t++) begin
      build_exp(bases[t], lens[t]);
      run_msg(bases[t], lens[t], 0);
      checks++;
      if (done_t - start_t != lens[t] / 4 + 3) begin
        failures++; $display("FAIL b2b_throughput[%0d]: got done@%0d, required done@%0d", t,
                             done_t - start_t, lens[t] / 4 + 3);
      end
      checks++;
      if (obs_q != exp_q) begin
        failures++; $display("FAIL b2b_words[%0d]: got %0d xfers, required %0d matching model", t,
                             obs_q.size(), exp_q.size());
      end
      checks++;
      if (rd_addr_q != exp_addr_q) begin
        failures++; $display("FAIL b2b_addrs[%0d]: got %0d reads first=%h, required %0d from %h", t,
                             rd_addr_q.size(), (rd_addr_q.size() > 0) ? rd_addr_q[0] : 10'h0,
                             exp_addr_q.size(), exp_addr_q[0]);
      end
    end
  endtask

  task automatic test_restart();
    int n_at_reset;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    // second start while busy must be ignored
    build_exp(100, 40);
    clear_cap(); cap = 1'b1;
    drive_start(100, 40);
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; msg_base = 10'd300; msg_len = 16'd8;
    @(posedge clk); #1;
    start = 1'b0;
    drive_until_done(0);
    checks++;
    if (obs_q != exp_q || done_cnt != 1) begin
      failures++; $display("FAIL restart_ignored: got %0d xfers done_cnt=%0d, required %0d model words and 1 done",
                           obs_q.size(), done_cnt, exp_q.size());
    end
    // reset mid-message
    clear_cap(); cap = 1'b1;
    drive_start(100, 40);
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL mid_busy: got %b, required 1", busy);
    end
    #2 reset = 1'b0;
    #1;
    n_at_reset = obs_q.size();
    checks++;
    if ({busy, done, mem_rd_en, mem_addr, pad_in, pad_in_ready, pad_is_last, pad_byte_num} !== '0) begin
      failures++; $display("FAIL midreset_outputs: got busy=%b rd=%b pad=%h rdy=%b, required all 0",
                           busy, mem_rd_en, pad_in, pad_in_ready);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    cap = 1'b0;
    checks++;
    if (done_cnt != 0 || obs_q.size() != n_at_reset) begin
      failures++; $display("FAIL midreset_quiet: got done_cnt=%0d extra xfers=%0d, required 0 and 0",
                           done_cnt, obs_q.size() - n_at_reset);
    end
    build_exp(50, 9);
    run_msg(50, 9, 1);
    checks++;
    if (obs_q != exp_q || rd_addr_q != exp_addr_q) begin
      failures++; $display("FAIL post_reset_run: got %0d xfers %0d reads, required %0d and %0d",
                           obs_q.size(), rd_addr_q.size(), exp_q.size(), exp_addr_q.size());
    end
    // start presented during the DONE cycle must be ignored
    clear_cap(); cap = 1'b1;
    drive_start(8, 0);
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1) begin
      failures++; $display("FAIL done_cycle: got done=%b at T2, required 1", done);
    end
    start = 1'b1; msg_base = 10'd8; msg_len = 16'd12;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    cap = 1'b0;
    checks++;
    if (obs_q.size() != 1 || rd_addr_q.size() != 0 || done_cnt != 1 || busy !== 1'b0) begin
      failures++; $display("FAIL start_in_done: got %0d xfers %0d reads %0d dones busy=%b, required 1 0 1 0",
                           obs_q.size(), rd_addr_q.size(), done_cnt, busy);
    end
  endtask

  task automatic test_random();
    int base, len, mode;
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      base = $urandom_range(0, 1023);
      len  = $urandom_range(0, 90);
      mode = $urandom_range(0, 1);
      build_exp(base, len);
      run_msg(base, len, mode);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        failures++; $display("FAIL rand%0d_count: len=%0d got %0d xfers, required %0d", it, len,
                             obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL rand%0d_word[%0d]: got %h, required %h", it, i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (rd_addr_q != exp_addr_q) begin
        failures++; $display("FAIL rand%0d_addrs: base=%0d len=%0d got %0d reads, required %0d", it,
                             base, len, rd_addr_q.size(), exp_addr_q.size());
      end
      checks++;
      if (done_cnt != 1 || done_t - last_xfer_t != 1 || stab_err != 0 || bn_err != 0) begin
        failures++; $display("FAIL rand%0d_proto: got dones=%0d gap=%0d unstable=%0d bn_err=%0d, required 1 1 0 0",
                             it, done_cnt, done_t - last_xfer_t, stab_err, bn_err);
      end
    end
  endtask

  initial begin
    cap = 1'b0;
    tcyc = 0;
    clear_cap();
    test_reset();
    test_len1();
    test_len4();
    test_len0();
    test_stall71();
    test_byteswap();
    test_back_to_back();
    test_restart();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
